fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/mips_pkg.sv | 33 +++
 rtl/pc_next_logic.sv | 27 ++
 rtl/fetch_unit.sv | 119 +++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode constants, next-PC select encodings,
// fetch FSM state encodings and a small immediate helper.
package mips_pkg;

  // Primary opcode field values (instr[31:26])
  localparam logic [5:0] OP_R     = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Next-PC source selected by the control FSM
  typedef enum logic [1:0] {
    SEL_PC4    = 2'b00,
    SEL_JUMP   = 2'b01,
    SEL_BRANCH = 2'b10,
    SEL_HOLD   = 2'b11
  } sel_pc_t;

  // Instruction fetch handshake states
  typedef enum logic [1:0] {
    F_IDLE = 2'b00,
    F_WAIT = 2'b01,
    F_DONE = 2'b10
  } fetch_state_t;

  // Sign-extend a 16-bit immediate to a full word
  function automatic logic [31:0] sign_extend16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/pc_next_logic.sv
// Combinational next-PC selection: sequential, jump, conditional branch
// or hold. All arithmetic is 32-bit and wraps silently.
import mips_pkg::*;

module pc_next_logic (
  input  logic [31:0] pc,
  input  logic [31:0] pc_plus4,
  input  logic [25:0] jump_index,
  input  logic [31:0] imm_sext,
  input  logic        zero,
  input  logic [1:0]  sel_pc,
  output logic [31:0] pc_next
);

  // Pick the next PC; a branch only leaves the sequential path when zero is set
  always_comb begin
    pc_next = pc;
    case (sel_pc_t'(sel_pc))
      SEL_PC4:    pc_next = pc_plus4;
      SEL_JUMP:   pc_next = {pc_plus4[31:28], jump_index, 2'b00};
      SEL_BRANCH: pc_next = zero ? (pc_plus4 + (imm_sext << 2)) : pc_plus4;
      SEL_HOLD:   pc_next = pc;
      default:    pc_next = pc;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: holds the PC and instruction register, runs the
// request/ack handshake with instruction memory, aborts a fetch that waits
// too long and decodes the instruction fields.
import mips_pkg::*;

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pc_ld,
  input  logic [1:0]  sel_pc,
  input  logic        ir_w,
  input  logic        mem_rd,
  input  logic        zero,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [5:0]  funct,
  output logic [31:0] imm_sext,
  output logic        fetch_busy,
  output logic        fetch_err
);

  localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  fetch_state_t     state;
  logic [CNT_W-1:0] wait_cnt;
  logic [31:0]      pc_next;

  assign pc_plus4 = pc + 32'd4;
  assign opcode   = instr[31:26];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign funct    = instr[5:0];
  assign imm_sext = sign_extend16(instr[15:0]);

  pc_next_logic u_pc_next (
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .jump_index (instr[25:0]),
    .imm_sext   (imm_sext),
    .zero       (zero),
    .sel_pc     (sel_pc),
    .pc_next    (pc_next)
  );

  // Fetch FSM: latch the address, wait for ack or timeout, capture the instruction
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= F_IDLE;
      imem_req   <= 1'b0;
      fetch_busy <= 1'b0;
      imem_addr  <= RESET_PC;
      instr      <= '0;
      wait_cnt   <= '0;
      fetch_err  <= 1'b0;
    end else begin
      case (state)
        F_IDLE: begin
          if (ir_w && mem_rd) begin
            imem_addr  <= pc;
            imem_req   <= 1'b1;
            fetch_busy <= 1'b1;
            wait_cnt   <= '0;
            state      <= F_WAIT;
          end
        end
        F_WAIT: begin
          if (imem_ack) begin
            instr      <= imem_rdata;
            imem_req   <= 1'b0;
            fetch_busy <= 1'b0;
            wait_cnt   <= '0;
            state      <= F_DONE;
          end else if (wait_cnt == CNT_LAST) begin
            fetch_err  <= 1'b1;
            imem_req   <= 1'b0;
            fetch_busy <= 1'b0;
            wait_cnt   <= '0;
            state      <= F_IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        F_DONE: begin
          state <= F_IDLE;
        end
        default: begin
          state      <= F_IDLE;
          imem_req   <= 1'b0;
          fetch_busy <= 1'b0;
          wait_cnt   <= '0;
        end
      endcase
    end
  end

  // PC register: loads only when no fetch is outstanding
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (pc_ld && !fetch_busy) begin
      pc <= pc_next;
    end
  end

endmodule
